// File: rtl/mem_test_pkg.sv
// Shared types for the memory pattern tester: pattern modes, FSM states and LFSR taps.
package mem_test_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR     = 2'd0,
    MODE_ADDR_INV = 2'd1,
    MODE_LFSR     = 2'd2,
    MODE_CHECKER  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Right-shifting Galois tap masks for maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int dw);
    case (dw)
      8:       return 32'h0000_00B8;
      32:      return 32'h8020_0003;
      default: return 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/mem_pattern_tester_if.sv
// Generic single-outstanding req/ack memory port; the tester is master, the RAM is slave.
interface mem_pattern_tester_if #(
  parameter int AW = 20,
  parameter int DW = 16
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lfsr_gen.sv
// DW-bit Galois LFSR; load reseeds with SEED^seed_xor (zero forced to 1), step advances once.
// Latency: value updates the cycle after load/step; load wins over step; no backpressure.
module lfsr_gen
  import mem_test_pkg::*;
#(
  parameter int          DW   = 16,
  parameter logic [31:0] SEED = 32'hACE1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] seed_xor,
  output logic [DW-1:0] value
);

  localparam logic [DW-1:0] TAPS   = DW'(lfsr_taps(DW));
  localparam logic [DW-1:0] SEED_W = DW'(SEED);

  logic [DW-1:0] seed_val;

  // An all-zero state would lock the register, so it is replaced by 1.
  always_comb begin
    seed_val = SEED_W ^ seed_xor;
    if (seed_val == '0) seed_val = DW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= '0;
    end else if (load) begin
      value <= seed_val;
    end else if (step) begin
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/mem_pattern_tester.sv
// Memory self-test: PASSES x (fill 2**AW words with a pattern, read back, compare); reports result.
// Latency: 2*PASSES*2**AW acks, done one cycle after the last ack; each request is held until mem_ack.
module mem_pattern_tester
  import mem_test_pkg::*;
#(
  parameter int          AW     = 20,
  parameter int          DW     = 16,
  parameter int          PASSES = 2,
  parameter int          ECW    = 16,
  parameter logic [31:0] SEED   = 32'hACE1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [1:0]           mode,
  mem_pattern_tester_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 passed,
  output logic [ECW-1:0]       err_count,
  output logic [AW-1:0]        first_err_addr,
  output logic [DW-1:0]        first_err_data
);

  localparam int            PW        = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  state_e        state;
  mode_e         mode_q;
  logic [PW-1:0] pass_q;
  logic [AW-1:0] addr_q;
  logic          req_q;
  logic          we_q;
  logic          err_seen;

  logic [DW-1:0] pat;
  logic [DW-1:0] addr_pat;
  logic [DW-1:0] lfsr_val;
  logic [DW-1:0] lfsr_seed_xor;
  logic          lfsr_load;
  logic          lfsr_step;
  logic          acked;
  logic          addr_last;
  logic          is_last_pass;
  logic          miss;
  logic          idle_start;

  // req_q is high exactly in WRITE/READ, so it also filters stray acks.
  assign acked        = req_q && mem.mem_ack;
  assign addr_last    = (addr_q == '1);
  assign is_last_pass = (pass_q == LAST_PASS);
  assign miss         = (state == ST_READ) && acked && (mem.mem_rdata != pat);
  assign idle_start   = ((state == ST_IDLE) || (state == ST_DONE)) && start;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = pat;

  always_comb begin
    addr_pat = DW'(addr_q);
    pat      = '0;
    case (mode_q)
      MODE_ADDR:     pat = addr_pat ^ {DW{pass_q[0]}};
      MODE_ADDR_INV: pat = ~(addr_pat ^ {DW{pass_q[0]}});
      MODE_LFSR:     pat = lfsr_val;
      MODE_CHECKER:  pat = (addr_q[0] ^ pass_q[0]) ? {DW/2{2'b10}} : {DW/2{2'b01}};
      default:       pat = '0;
    endcase
  end

  // Reseed on entry to every phase so READ replays the exact WRITE sequence.
  always_comb begin
    lfsr_load     = 1'b0;
    lfsr_seed_xor = '0;
    lfsr_step     = acked;
    if (idle_start) begin
      lfsr_load = 1'b1;
    end else if (acked && addr_last) begin
      if (state == ST_WRITE) begin
        lfsr_load     = 1'b1;
        lfsr_seed_xor = DW'(pass_q);
      end else if (!is_last_pass) begin
        lfsr_load     = 1'b1;
        lfsr_seed_xor = DW'(pass_q + PW'(1));
      end
    end
  end

  lfsr_gen #(
    .DW   (DW),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .resetn   (resetn),
    .load     (lfsr_load),
    .step     (lfsr_step),
    .seed_xor (lfsr_seed_xor),
    .value    (lfsr_val)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      mode_q         <= MODE_ADDR;
      pass_q         <= '0;
      addr_q         <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      err_seen       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      passed         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_q         <= mode_e'(mode);
            pass_q         <= '0;
            addr_q         <= '0;
            req_q          <= 1'b1;
            we_q           <= 1'b1;
            err_seen       <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            passed         <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            state          <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (acked) begin
            addr_q <= addr_q + AW'(1);
            if (addr_last) begin
              we_q  <= 1'b0;
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (acked) begin
            if (miss) begin
              if (err_count != '1) err_count <= err_count + ECW'(1);
              if (!err_seen) begin
                err_seen       <= 1'b1;
                first_err_addr <= addr_q;
                first_err_data <= mem.mem_rdata;
              end
            end
            addr_q <= addr_q + AW'(1);
            if (addr_last) begin
              if (is_last_pass) begin
                req_q  <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
                passed <= !err_seen && !miss;
                state  <= ST_DONE;
              end else begin
                pass_q <= pass_q + PW'(1);
                we_q   <= 1'b1;
                state  <= ST_WRITE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Directed bench: RAM model with optional stalls, stuck bit and read corruption around mem_pattern_tester.
module tb_mem_pattern_tester;
  import mem_test_pkg::*;

  localparam int AW = 4, DW = 8, PASSES = 2, ECW = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic           start;
  logic [1:0]     mode;
  logic           busy, done, passed;
  logic [ECW-1:0] err_count;
  logic [AW-1:0]  first_err_addr;
  logic [DW-1:0]  first_err_data;

  mem_pattern_tester_if #(.AW(AW), .DW(DW)) bus ();

  mem_pattern_tester #(.AW(AW), .DW(DW), .PASSES(PASSES), .ECW(ECW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .mode           (mode),
    .mem            (bus),
    .busy           (busy),
    .done           (done),
    .passed         (passed),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] ram [16];
  logic [DW-1:0] wlog [1024];
  int            wcnt = 0;
  int            ack_cnt = 0;
  int            stall_viol = 0;
  int            dly;
  int            max_delay = 0;
  bit            stuck = 0;
  bit            corrupt = 0;
  logic          spur_ack = 1'b0;
  logic          ram_ack;
  logic [DW-1:0] ram_rdata;

  assign bus.mem_ack   = ram_ack | spur_ack;
  assign bus.mem_rdata = ram_rdata;

  // RAM acks one cycle after a request (plus an optional random stall).
  always @(posedge clk or negedge resetn) begin : ram_model
    logic [DW-1:0] rd;
    if (!resetn) begin
      ram_ack   <= 1'b0;
      ram_rdata <= '0;
      dly       <= 0;
    end else if (ram_ack) begin
      ram_ack <= 1'b0;
    end else if (bus.mem_req) begin
      if (dly != 0) begin
        dly <= dly - 1;
      end else begin
        ram_ack <= 1'b1;
        dly     <= $urandom_range(max_delay, 0);
        if (bus.mem_we) begin
          ram[bus.mem_addr] <= bus.mem_wdata;
          wlog[wcnt % 1024] <= bus.mem_wdata;
          wcnt              <= wcnt + 1;
        end else begin
          rd = ram[bus.mem_addr];
          if (stuck && bus.mem_addr == 4'd5) rd[2] = 1'b0;
          if (corrupt) rd = rd ^ 8'hFF;
          ram_rdata <= rd;
        end
      end
    end
  end

  logic          prev_stall = 1'b0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_we;

  always @(negedge clk) begin
    if (bus.mem_req && bus.mem_ack) ack_cnt++;
    if (prev_stall && bus.mem_req &&
        (bus.mem_addr !== p_addr || bus.mem_wdata !== p_wdata || bus.mem_we !== p_we))
      stall_viol++;
    prev_stall = bus.mem_req && !bus.mem_ack;
    p_addr     = bus.mem_addr;
    p_wdata    = bus.mem_wdata;
    p_we       = bus.mem_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, w0, sv, n;
    resetn = 1'b0;
    start  = 1'b0;
    mode   = 2'd0;
    tick(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_passed", 32'(passed), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_req", 32'(bus.mem_req), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);
    check("rst_fea", 32'(first_err_addr), 0);
    check("rst_fed", 32'(first_err_data), 0);
    resetn = 1'b1;
    tick();

    // Stray ack while idle must not start anything.
    spur_ack = 1'b1;
    tick(2);
    spur_ack = 1'b0;
    check("idle_spur_busy", 32'(busy), 0);
    check("idle_spur_req", 32'(bus.mem_req), 0);

    // 1: ADDR pattern, clean RAM
    a0 = ack_cnt; w0 = wcnt;
    pulse_start(MODE_ADDR);
    check("t1_busy", 32'(busy), 1);
    check("t1_req", 32'(bus.mem_req), 1);
    check("t1_we", 32'(bus.mem_we), 1);
    wait_done("t1");
    check("t1_acks", ack_cnt - a0, 64);
    check("t1_passed", 32'(passed), 1);
    check("t1_err", 32'(err_count), 0);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_req_end", 32'(bus.mem_req), 0);
    check("t1_p0_a3", 32'(wlog[(w0 + 3) % 1024]), 32'h03);
    check("t1_p1_a3", 32'(wlog[(w0 + 19) % 1024]), 32'hFC);

    // 2: bit 2 of addr 5 stuck low
    stuck = 1;
    pulse_start(MODE_ADDR);
    wait_done("t2");
    check("t2_err", 32'(err_count), 1);
    check("t2_fea", 32'(first_err_addr), 5);
    check("t2_fed", 32'(first_err_data), 32'h01);
    check("t2_passed", 32'(passed), 0);
    stuck = 0;

    // 3: LFSR with random stalls
    max_delay = 3;
    a0 = ack_cnt; w0 = wcnt; sv = stall_viol;
    pulse_start(MODE_LFSR);
    wait_done("t3");
    max_delay = 0;
    check("t3_acks", ack_cnt - a0, 64);
    check("t3_passed", 32'(passed), 1);
    check("t3_err", 32'(err_count), 0);
    check("t3_stall_stable", stall_viol - sv, 0);
    check("t3_p0_a0", 32'(wlog[w0 % 1024]), 32'hE1);
    check("t3_p0_a1", 32'(wlog[(w0 + 1) % 1024]), 32'hC8);
    check("t3_p1_a0", 32'(wlog[(w0 + 16) % 1024]), 32'hE0);
    check("t3_p1_a1", 32'(wlog[(w0 + 17) % 1024]), 32'h70);

    // 4: reset in the middle of pass-0 READ, then a full rerun
    stuck = 1;
    pulse_start(MODE_ADDR);
    n = 0;
    while (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr === 4'd8) && n < 500) begin
      tick();
      n++;
    end
    check("t4_in_read", {26'd0, bus.mem_req, bus.mem_we, bus.mem_addr}, {26'd0, 1'b1, 1'b0, 4'd8});
    check("t4_pre_err", 32'(err_count), 1);
    #2 resetn = 1'b0;
    #1;
    check("t4_rst_req", 32'(bus.mem_req), 0);
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_done", 32'(done), 0);
    check("t4_rst_err", 32'(err_count), 0);
    check("t4_rst_fea", 32'(first_err_addr), 0);
    check("t4_rst_fed", 32'(first_err_data), 0);
    tick();
    resetn = 1'b1;
    stuck  = 0;
    tick();
    a0 = ack_cnt;
    pulse_start(MODE_ADDR);
    wait_done("t4");
    check("t4_acks", ack_cnt - a0, 64);
    check("t4_passed", 32'(passed), 1);

    // 5: every read corrupted, 2-bit count saturates
    corrupt = 1;
    pulse_start(MODE_ADDR);
    wait_done("t5");
    check("t5_err_sat", 32'(err_count), 3);
    check("t5_fea", 32'(first_err_addr), 0);
    check("t5_fed", 32'(first_err_data), 32'hFF);
    check("t5_passed", 32'(passed), 0);
    corrupt = 0;

    // 6: CHECKER; start and mode change mid-run ignored; stray ack in DONE ignored
    a0 = ack_cnt; w0 = wcnt;
    pulse_start(MODE_CHECKER);
    tick(5);
    pulse_start(MODE_ADDR);
    wait_done("t6");
    check("t6_acks", ack_cnt - a0, 64);
    check("t6_passed", 32'(passed), 1);
    check("t6_p0_a0", 32'(wlog[w0 % 1024]), 32'h55);
    check("t6_p0_a1", 32'(wlog[(w0 + 1) % 1024]), 32'hAA);
    check("t6_p1_a0", 32'(wlog[(w0 + 16) % 1024]), 32'hAA);
    spur_ack = 1'b1;
    tick(2);
    spur_ack = 1'b0;
    check("t6_spur_done", 32'(done), 1);
    check("t6_spur_busy", 32'(busy), 0);
    check("t6_spur_req", 32'(bus.mem_req), 0);
    check("t6_spur_acks", ack_cnt - a0, 64);

    // 7: ADDR_INV
    w0 = wcnt;
    pulse_start(MODE_ADDR_INV);
    wait_done("t7");
    check("t7_passed", 32'(passed), 1);
    check("t7_p0_a3", 32'(wlog[(w0 + 3) % 1024]), 32'hFC);
    check("t7_p1_a3", 32'(wlog[(w0 + 19) % 1024]), 32'h03);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
